// File: rtl/ram_fifo_ctrl_if.sv
// ram_fifo_ctrl_if: push/pop stream bundle between a producer/consumer and the RAM FIFO controller
// Ports (slave = controller side):
//   push_valid, push_data, pop_ready   producer/consumer -> controller
//   push_ready, pop_valid, pop_data    controller -> producer/consumer
//   level                              words held (RAM + in-flight read + output buffer)
interface ram_fifo_ctrl_if #(
  parameter int ADDR_W = 4,
  parameter int BYTES  = 4
);
  logic                push_valid;
  logic                push_ready;
  logic [8*BYTES-1:0]  push_data;
  logic                pop_valid;
  logic                pop_ready;
  logic [8*BYTES-1:0]  pop_data;
  logic [ADDR_W+1:0]   level;
  modport slave (
    input  push_valid, push_data, pop_ready,
    output push_ready, pop_valid, pop_data, level
  );
  modport master (
    output push_valid, push_data, pop_ready,
    input  push_ready, pop_valid, pop_data, level
  );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: single-clock FIFO controller driving a 1W/1R byte-masked RAM with 1-cycle read latency
// Ports:
//   clk, resetn          clock and async active-low reset
//   bus                  push/pop stream interface (slave modport)
//   ram_wr_en/mask/addr/data   RAM write port (mask is always all ones)
//   ram_rd_en/addr       RAM read request
//   ram_rd_data          RAM registered read data, valid the cycle after ram_rd_en
module ram_fifo_ctrl #(
  parameter int ADDR_W = 4,
  parameter int BYTES  = 4
) (
  input  logic                clk,
  input  logic                resetn,
  ram_fifo_ctrl_if.slave      bus,
  output logic                ram_wr_en,
  output logic [BYTES-1:0]    ram_wr_mask,
  output logic [ADDR_W-1:0]   ram_wr_addr,
  output logic [8*BYTES-1:0]  ram_wr_data,
  output logic                ram_rd_en,
  output logic [ADDR_W-1:0]   ram_rd_addr,
  input  logic [8*BYTES-1:0]  ram_rd_data
);
  logic [ADDR_W:0]    wr_ptr, rd_ptr, ram_cnt;
  logic               inflight, hd, ram_empty, ram_full, push_fire, pop_fire;
  logic [1:0]         buf_cnt;
  logic [8*BYTES-1:0] obuf [2];
  assign ram_empty = wr_ptr == rd_ptr;
  assign ram_full = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) && (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign bus.push_ready = resetn && !ram_full;
  assign push_fire = bus.push_valid && bus.push_ready;
  assign bus.pop_valid = buf_cnt != 2'd0;
  assign pop_fire = bus.pop_valid && bus.pop_ready;
  // Issue a read only if the output buffer can still absorb it once the in-flight word lands.
  assign ram_rd_en = !ram_empty && (({1'b0, buf_cnt} + {2'b0, inflight}) < (3'd2 + {2'b0, pop_fire}));
  assign ram_rd_addr = rd_ptr[ADDR_W-1:0];
  assign ram_wr_en = push_fire;
  assign ram_wr_mask = '1;
  assign ram_wr_addr = wr_ptr[ADDR_W-1:0];
  assign ram_wr_data = bus.push_data;
  assign bus.pop_data = obuf[hd];
  assign ram_cnt = wr_ptr - rd_ptr;
  assign bus.level = {1'b0, ram_cnt} + {{(ADDR_W+1){1'b0}}, inflight} + {{ADDR_W{1'b0}}, buf_cnt};
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      inflight <= 1'b0;
      buf_cnt  <= 2'd0;
      hd       <= 1'b0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + 1'b1;
      if (ram_rd_en) rd_ptr <= rd_ptr + 1'b1;
      inflight <= ram_rd_en;
      buf_cnt  <= buf_cnt + {1'b0, inflight} - {1'b0, pop_fire};
      if (pop_fire) hd <= !hd;
    end
  // Returning word lands at the tail; with at most one word held the tail is head ^ count.
  always_ff @(posedge clk)
    if (inflight) obuf[hd ^ buf_cnt[0]] <= ram_rd_data;
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb_ram_fifo_ctrl: scoreboard bench for ram_fifo_ctrl with a behavioural 1-cycle-latency RAM
module tb_ram_fifo_ctrl;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        ram_wr_en, ram_rd_en;
  logic [3:0]  ram_wr_mask, ram_wr_addr, ram_rd_addr;
  logic [31:0] ram_wr_data, ram_rd_data;
  logic [31:0] mem [16];
  logic [31:0] exp_q [$];
  int          nvec = 0, nerr = 0, mdl_level = 0, npop = 0, nxt, cnt, p0;
  ram_fifo_ctrl_if #(.ADDR_W(4), .BYTES(4)) b ();
  ram_fifo_ctrl #(.ADDR_W(4), .BYTES(4)) dut (
    .clk(clk), .resetn(resetn), .bus(b),
    .ram_wr_en(ram_wr_en), .ram_wr_mask(ram_wr_mask), .ram_wr_addr(ram_wr_addr),
    .ram_wr_data(ram_wr_data), .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr),
    .ram_rd_data(ram_rd_data)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
  end
  task automatic chk(input string tag, input longint unsigned got, input longint unsigned exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  always @(negedge clk)
    if (resetn) begin
      chk("level", b.level, mdl_level);
      if (ram_wr_en) chk("wr_mask", ram_wr_mask, 4'hF);
      if (ram_wr_en && ram_rd_en) chk("rd_wr_addr_clash", ram_wr_addr == ram_rd_addr, 0);
      if (b.pop_valid && b.pop_ready) begin
        npop++;
        if (exp_q.size() == 0) chk("pop_extra_qsize", exp_q.size(), 1);
        else chk("pop_data", b.pop_data, exp_q.pop_front());
        mdl_level--;
      end
      if (b.push_valid && b.push_ready) begin
        exp_q.push_back(b.push_data);
        mdl_level++;
      end
    end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    resetn = 1'b0;
    b.push_valid = 1'b0;
    b.push_data = '0;
    b.pop_ready = 1'b0;
    exp_q.delete();
    mdl_level = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pop_valid", b.pop_valid, 0);
    chk("rst_level", b.level, 0);
    chk("rst_push_ready", b.push_ready, 0);
    chk("rst_rd_en", ram_rd_en, 0);
    resetn = 1'b1;
  endtask
  task automatic drain();
    b.push_valid = 1'b0;
    b.pop_ready = 1'b1;
    for (int c = 0; c < 60 && exp_q.size() != 0; c++) cyc();
    cyc();
    chk("drain_qsize", exp_q.size(), 0);
    chk("drain_level", b.level, 0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    // T1: single word latency
    do_reset();
    cyc();
    b.pop_ready = 1'b1;
    b.push_valid = 1'b1;
    b.push_data = 32'h1122_3344;
    #1;
    chk("t1_wr_en_c0", ram_wr_en, 1);
    chk("t1_rd_en_c0", ram_rd_en, 0);
    cyc();
    b.push_valid = 1'b0;
    #1;
    chk("t1_rd_en_c1", ram_rd_en, 1);
    chk("t1_pop_valid_c1", b.pop_valid, 0);
    cyc();
    chk("t1_pop_valid_c2", b.pop_valid, 0);
    cyc();
    chk("t1_pop_valid_c3", b.pop_valid, 1);
    chk("t1_pop_data_c3", b.pop_data, 32'h1122_3344);
    chk("t1_level_c3", b.level, 1);
    cyc();
    chk("t1_level_after", b.level, 0);
    chk("t1_pop_valid_after", b.pop_valid, 0);
    // T2: fill with consumer stalled
    do_reset();
    nxt = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      b.push_valid = 1'b1;
      b.push_data = nxt;
      #1;
      if (b.push_ready) nxt++;
    end
    chk("t2_accepted", nxt, 18);
    cyc();
    b.push_data = nxt;
    #1;
    chk("t2_level", b.level, 18);
    chk("t2_push_ready", b.push_ready, 0);
    chk("t2_rd_en", ram_rd_en, 0);
    // T3: release consumer while still pushing
    b.pop_ready = 1'b1;
    #1;
    chk("t3_rd_en_first", ram_rd_en, 1);
    chk("t3_push_ready_same", b.push_ready, 0);
    cyc();
    chk("t3_push_ready_next", b.push_ready, 1);
    if (b.push_ready) nxt++;
    for (int i = 0; i < 40; i++) begin
      cyc();
      b.push_data = nxt;
      #1;
      chk("t3_pop_every_cycle", b.pop_valid, 1);
      if (b.push_ready) nxt++;
    end
    drain();
    // T4: random traffic
    do_reset();
    cnt = 0;
    for (int c = 0; c < 6000 && cnt < 1000; c++) begin
      cyc();
      b.push_valid = 1'($urandom_range(0, 1));
      b.push_data = $urandom;
      b.pop_ready = 1'($urandom_range(0, 1));
      #1;
      if (b.push_valid && b.push_ready) cnt++;
    end
    chk("t4_pushed", cnt, 1000);
    drain();
    // T5: async reset with content held
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cyc();
      b.push_valid = 1'b1;
      b.push_data = $urandom;
    end
    cyc();
    b.push_valid = 1'b0;
    repeat (3) cyc();
    chk("t5_level_held", b.level, 5);
    #2;
    resetn = 1'b0;
    exp_q.delete();
    mdl_level = 0;
    #1;
    chk("t5_pop_valid_rst", b.pop_valid, 0);
    chk("t5_level_rst", b.level, 0);
    cyc();
    resetn = 1'b1;
    cyc();
    p0 = npop;
    b.push_valid = 1'b1;
    b.push_data = 32'hA5A5_A5A5;
    b.pop_ready = 1'b1;
    cyc();
    b.push_valid = 1'b0;
    repeat (8) cyc();
    chk("t5_pop_count", npop - p0, 1);
    chk("t5_qsize", exp_q.size(), 0);
    // T6: simultaneous push and pop every cycle
    do_reset();
    b.pop_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      cyc();
      b.push_valid = 1'b1;
      b.push_data = 32'hC000_0000 + i;
    end
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
